// File: rtl/puf_ro_ctrl_pkg.sv
// Shared types, default sizing and challenge legality check for the RO-PUF
// measurement controller.
package puf_ro_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SETTLE  = 2'd1,
      MEASURE = 2'd2,
      COMPARE = 2'd3
   } state_e;

   localparam int unsigned DEF_N_RO          = 16;
   localparam int unsigned DEF_SEL_W         = 4;
   localparam int unsigned DEF_CNT_BIT_SIZE  = 16;
   localparam int unsigned DEF_SETTLE_CYCLES = 8;
   localparam int unsigned DEF_WIN_CYCLES    = 1024;

   // Two distinct oscillators, both present in the array.
   function automatic logic challenge_legal(input int unsigned sel_a,
                                            input int unsigned sel_b,
                                            input int unsigned n_ro);
      return (sel_a != sel_b) && (sel_a < n_ro) && (sel_b < n_ro);
   endfunction

endpackage

// File: rtl/puf_edge_cnt.sv
// One measurement channel: 2-flop synchronizer, registered rising-edge
// detect and a saturating edge counter with synchronous clear and enable.
module puf_edge_cnt
   import puf_ro_ctrl_pkg::*;
#(
   parameter int unsigned CNT_BIT_SIZE = DEF_CNT_BIT_SIZE
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    ro,
   input  logic                    clr,
   input  logic                    en,
   output logic [CNT_BIT_SIZE-1:0] cnt,
   output logic                    sat
);

   // [1:0] synchronizer stages, [2] previous synchronized value
   logic [2:0] sync_q;
   logic       rise;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[1:0], ro};
      end
   end

   assign rise = sync_q[1] & ~sync_q[2];
   assign sat  = (cnt == '1);

   always_ff @(posedge clk) begin
      if (!rst_n || clr) begin
         cnt <= '0;
      end else if (en && rise && !sat) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/puf_ro_ctrl.sv
// Ring-oscillator PUF measurement controller: enables a challenge-selected
// oscillator pair, counts edges over a fixed window and compares the counts.
module puf_ro_ctrl
   import puf_ro_ctrl_pkg::*;
#(
   parameter int unsigned N_RO          = DEF_N_RO,
   parameter int unsigned SEL_W         = DEF_SEL_W,
   parameter int unsigned CNT_BIT_SIZE  = DEF_CNT_BIT_SIZE,
   parameter int unsigned SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int unsigned WIN_CYCLES    = DEF_WIN_CYCLES
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic                    i_start,
   input  logic [2*SEL_W-1:0]      i_challenge,
   input  logic [N_RO-1:0]         i_ro,
   output logic [N_RO-1:0]         o_ro_en,
   output logic                    o_busy,
   output logic                    o_done,
   output logic                    o_response,
   output logic [CNT_BIT_SIZE-1:0] o_cnt_a,
   output logic [CNT_BIT_SIZE-1:0] o_cnt_b,
   output logic                    o_err
);

   localparam int unsigned TMR_MAX = (WIN_CYCLES > SETTLE_CYCLES) ? WIN_CYCLES : SETTLE_CYCLES;
   localparam int unsigned TMR_W   = $clog2(TMR_MAX);

   state_e                  state_q, state_d;
   logic [TMR_W-1:0]        tmr_q, tmr_d;
   logic [SEL_W-1:0]        sel_a_in, sel_b_in;
   logic [SEL_W-1:0]        sel_a_q, sel_b_q;
   logic                    chal_ok;
   logic                    accept;
   logic [N_RO-1:0]         ro_en;
   logic                    ro_a, ro_b;
   logic [CNT_BIT_SIZE-1:0] cnt_a, cnt_b;
   logic                    sat_a, sat_b;

   assign sel_a_in = i_challenge[SEL_W-1:0];
   assign sel_b_in = i_challenge[2*SEL_W-1:SEL_W];
   assign chal_ok  = challenge_legal(32'(sel_a_in), 32'(sel_b_in), N_RO);
   assign accept   = (state_q == IDLE) && i_start;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      ro_en   = '0;
      case (state_q)
         IDLE: begin
            if (i_start && chal_ok) begin
               state_d = SETTLE;
               tmr_d   = '0;
            end
         end
         SETTLE: begin
            ro_en[sel_a_q] = 1'b1;
            ro_en[sel_b_q] = 1'b1;
            if (tmr_q == TMR_W'(SETTLE_CYCLES - 1)) begin
               state_d = MEASURE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         MEASURE: begin
            ro_en[sel_a_q] = 1'b1;
            ro_en[sel_b_q] = 1'b1;
            if (tmr_q == TMR_W'(WIN_CYCLES - 1)) begin
               state_d = COMPARE;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         COMPARE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Selects are only captured for a legal challenge, so the mux never
   // points outside the array.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         sel_a_q <= '0;
         sel_b_q <= '0;
      end else if (accept && chal_ok) begin
         sel_a_q <= sel_a_in;
         sel_b_q <= sel_b_in;
      end
   end

   assign ro_a = i_ro[sel_a_q];
   assign ro_b = i_ro[sel_b_q];

   puf_edge_cnt #(.CNT_BIT_SIZE(CNT_BIT_SIZE)) u_cnt_a (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .ro    (ro_a),
      .clr   (state_q == SETTLE),
      .en    (state_q == MEASURE),
      .cnt   (cnt_a),
      .sat   (sat_a)
   );

   puf_edge_cnt #(.CNT_BIT_SIZE(CNT_BIT_SIZE)) u_cnt_b (
      .clk   (i_clk),
      .rst_n (i_rst_n),
      .ro    (ro_b),
      .clr   (state_q == SETTLE),
      .en    (state_q == MEASURE),
      .cnt   (cnt_b),
      .sat   (sat_b)
   );

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_done     <= 1'b0;
         o_response <= 1'b0;
         o_cnt_a    <= '0;
         o_cnt_b    <= '0;
         o_err      <= 1'b0;
      end else begin
         o_done <= 1'b0;
         if (accept && !chal_ok) begin
            o_done     <= 1'b1;
            o_response <= 1'b0;
            o_cnt_a    <= '0;
            o_cnt_b    <= '0;
            o_err      <= 1'b1;
         end else if (state_q == COMPARE) begin
            o_done     <= 1'b1;
            o_response <= (cnt_a > cnt_b);
            o_cnt_a    <= cnt_a;
            o_cnt_b    <= cnt_b;
            o_err      <= sat_a | sat_b;
         end
      end
   end

   assign o_ro_en = ro_en;
   assign o_busy  = (state_q != IDLE);

endmodule

// File: tb/tb_puf_ro_ctrl.sv
// Scoreboard bench for puf_ro_ctrl: an 8-bit-counter instance and a 4-bit
// (saturating) instance share stimulus; a monitor checks each o_done.
module tb_puf_ro_ctrl;

   typedef struct {
      bit resp;
      int a;
      int tol_a;
      int b;
      int tol_b;
      bit err;
      int t_done;
   } exp_t;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic [7:0]  chal;
   logic [15:0] ro;
   bit          run;

   logic [15:0] en0, en1;
   logic        busy0, busy1, done0, done1, resp0, resp1, err0, err1;
   logic [7:0]  cnt_a0, cnt_b0;
   logic [3:0]  cnt_a1, cnt_b1;

   int   cyc = 0;
   int   n_cmp = 0;
   int   n_err = 0;
   exp_t q0[$];
   exp_t q1[$];

   puf_ro_ctrl #(
      .N_RO(16), .SEL_W(4), .CNT_BIT_SIZE(8), .SETTLE_CYCLES(4), .WIN_CYCLES(64)
   ) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_challenge(chal), .i_ro(ro),
      .o_ro_en(en0), .o_busy(busy0), .o_done(done0), .o_response(resp0),
      .o_cnt_a(cnt_a0), .o_cnt_b(cnt_b0), .o_err(err0)
   );

   puf_ro_ctrl #(
      .N_RO(16), .SEL_W(4), .CNT_BIT_SIZE(4), .SETTLE_CYCLES(4), .WIN_CYCLES(64)
   ) dut_sat (
      .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_challenge(chal), .i_ro(ro),
      .o_ro_en(en1), .o_busy(busy1), .o_done(done1), .o_response(resp1),
      .o_cnt_a(cnt_a1), .o_cnt_b(cnt_b1), .o_err(err1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Oscillator model: RO3 period 4 clocks, RO5 period 8 clocks.
   initial begin
      ro = '0;
      forever begin
         @(negedge clk);
         ro = '0;
         if (run) begin
            ro[3] = cyc[1];
            ro[5] = cyc[2];
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      n_cmp++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d",
                  name, act, act, exp, exp, cyc);
      end
   endtask

   task automatic chk_rng(input string name, input int act, input int exp, input int tol);
      n_cmp++;
      if (act < exp - tol || act > exp + tol) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d +/- %0d at cycle %0d",
                  name, act, exp, tol, cyc);
      end
   endtask

   task automatic mon_one(input int id, input logic done, input logic resp,
                          input int a, input int b, input logic err);
      exp_t e;
      bit   have;
      have = (id == 0) ? (q0.size() != 0) : (q1.size() != 0);
      if (have) begin
         if (id == 0) e = q0[0];
         else         e = q1[0];
      end
      if (done === 1'b1) begin
         if (!have) begin
            n_cmp++;
            n_err++;
            $display("FAIL d%0d_unexpected_done: got o_done=1 expected 0 at cycle %0d", id, cyc);
         end else begin
            chk($sformatf("d%0d_done_time", id), cyc, e.t_done);
            chk($sformatf("d%0d_response", id), int'(resp), int'(e.resp));
            chk($sformatf("d%0d_err", id), int'(err), int'(e.err));
            chk_rng($sformatf("d%0d_cnt_a", id), a, e.a, e.tol_a);
            chk_rng($sformatf("d%0d_cnt_b", id), b, e.b, e.tol_b);
            if (id == 0) void'(q0.pop_front());
            else         void'(q1.pop_front());
         end
      end else if (have && cyc > e.t_done) begin
         n_cmp++;
         n_err++;
         $display("FAIL d%0d_missing_done: got no o_done expected at cycle %0d", id, e.t_done);
         if (id == 0) void'(q0.pop_front());
         else         void'(q1.pop_front());
      end
   endtask

   always @(negedge clk) begin
      mon_one(0, done0, resp0, int'(cnt_a0), int'(cnt_b0), err0);
      mon_one(1, done1, resp1, int'(cnt_a1), int'(cnt_b1), err1);
   end

   task automatic step_to(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_en0"},   int'(en0), 0);
      chk({tag, "_en1"},   int'(en1), 0);
      chk({tag, "_busy0"}, int'(busy0), 0);
      chk({tag, "_busy1"}, int'(busy1), 0);
      chk({tag, "_done0"}, int'(done0), 0);
      chk({tag, "_resp0"}, int'(resp0), 0);
      chk({tag, "_cnta0"}, int'(cnt_a0), 0);
      chk({tag, "_cntb0"}, int'(cnt_b0), 0);
      chk({tag, "_err0"},  int'(err0), 0);
      chk({tag, "_err1"},  int'(err1), 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int t;
      rst_n = 1'b0;
      start = 1'b0;
      chal  = '0;
      run   = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero("reset");
      rst_n = 1'b1;
      @(negedge clk);

      // Basic measurement: sel_a=3, sel_b=5
      run   = 1'b1;
      chal  = 8'h53;
      start = 1'b1;
      t     = cyc;
      q0.push_back('{1'b1, 16, 1, 8, 1, 1'b0, t + 70});
      q1.push_back('{1'b1, 15, 0, 8, 1, 1'b1, t + 70});
      @(negedge clk);
      start = 1'b0;
      chk("basic_en_first", int'(en0), 16'h0028);
      chk("basic_busy_first", int'(busy0), 1);
      step_to(t + 10);
      chal  = 8'h21;   // start while busy, with a different challenge
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("busy_start_ignored_en", int'(en0), 16'h0028);
      step_to(t + 68);
      chk("basic_en_last", int'(en0), 16'h0028);
      chk("sat_en_last", int'(en1), 16'h0028);
      step_to(t + 69);
      chk("compare_en_off", int'(en0), 0);
      chk("compare_busy", int'(busy0), 1);
      step_to(t + 70);
      chk("done_cycle_busy", int'(busy0), 0);

      // Swapped selects, started in the o_done cycle
      chal  = 8'h35;
      start = 1'b1;
      t     = cyc;
      q0.push_back('{1'b0, 8, 1, 16, 1, 1'b0, t + 70});
      q1.push_back('{1'b0, 8, 1, 15, 0, 1'b1, t + 70});
      @(negedge clk);
      start = 1'b0;
      chk("start_in_done_busy", int'(busy0), 1);
      chk("swap_en", int'(en0), 16'h0028);
      step_to(t + 70);
      @(negedge clk);

      // Tie: oscillators held low
      run   = 1'b0;
      chal  = 8'h53;
      start = 1'b1;
      t     = cyc;
      q0.push_back('{1'b0, 0, 0, 0, 0, 1'b0, t + 70});
      q1.push_back('{1'b0, 0, 0, 0, 0, 1'b0, t + 70});
      @(negedge clk);
      start = 1'b0;
      step_to(t + 71);

      // Illegal challenge: sel_a == sel_b == 7
      chal  = 8'h77;
      start = 1'b1;
      t     = cyc;
      q0.push_back('{1'b0, 0, 0, 0, 0, 1'b1, t + 1});
      q1.push_back('{1'b0, 0, 0, 0, 0, 1'b1, t + 1});
      @(negedge clk);
      start = 1'b0;
      chk("illegal_en", int'(en0), 0);
      chk("illegal_busy", int'(busy0), 0);
      step_to(t + 4);
      chk("illegal_stays_idle", int'(busy0), 0);

      // Reset in the middle of a measurement
      run   = 1'b1;
      chal  = 8'h53;
      start = 1'b1;
      t     = cyc;
      @(negedge clk);
      start = 1'b0;
      step_to(t + 30);
      rst_n = 1'b0;
      @(negedge clk);
      chk_zero("midreset");
      rst_n = 1'b1;
      step_to(t + 90);
      chk("pending_q0", q0.size(), 0);
      chk("pending_q1", q1.size(), 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/puf_ro_ctrl.md
# puf_ro_ctrl

Measurement controller for the ring-oscillator PUF array. The ring oscillators are built from chains of PUF inverter cells. On a challenge, the block:

- enables the two ring oscillators selected by the challenge,
- waits for them to settle,
- counts rising edges of each over a fixed window,
- compares the counts and returns one response bit.

It sits between the host/challenge interface and the oscillator array, and it is the only block that drives the oscillator enables.

## Interface
Parameters:
- N_RO, 16: number of ring oscillators in the array.
- SEL_W, 4: width of one oscillator index; must satisfy 2**SEL_W >= N_RO.
- CNT_BIT_SIZE, 16: edge-counter width.
- SETTLE_CYCLES, 8: cycles between oscillator enable and the start of counting; must be >= 3.
- WIN_CYCLES, 1024: length of the counting window in clock cycles.

Ports:
- i_clk, input, 1: system clock. Synchronous reset is active-low.
- i_rst_n, input, 1: reset, synchronous, active-low.
- i_start, input, 1: start request; sampled only in IDLE.
- i_challenge, input, 2*SEL_W: [SEL_W-1:0] = sel_a, [2*SEL_W-1:SEL_W] = sel_b.
- i_ro, input, N_RO: raw oscillator outputs, asynchronous to i_clk.
- o_ro_en, output, N_RO: one-hot-pair oscillator enables.
- o_busy, output, 1: measurement in progress.
- o_done, output, 1: one-cycle pulse; response outputs are valid.
- o_response, output, 1: 1 when cnt_a > cnt_b.
- o_cnt_a, output, CNT_BIT_SIZE: edge count of sel_a.
- o_cnt_b, output, CNT_BIT_SIZE: edge count of sel_b.
- o_err, output, 1: illegal challenge or counter saturation.

## Operation
FSM states: IDLE, SETTLE, MEASURE, COMPARE.

- **IDLE**
  - On i_start=1, latch i_challenge.
  - If the challenge is legal (sel_a != sel_b, both < N_RO), go to SETTLE.
  - If illegal, stay in IDLE, pulse o_done next cycle with o_err=1, o_response=0, counts=0, and assert no enables.
- **SETTLE**
  - o_ro_en[sel_a] = o_ro_en[sel_b] = 1; all other enables 0.
  - Edge counters cleared; synchronizers running.
  - Lasts SETTLE_CYCLES cycles, then go to MEASURE.
- **MEASURE**
  - Each edge counter increments by 1 per synchronized rising edge of its selected oscillator.
  - Lasts WIN_CYCLES cycles, then go to COMPARE.
- **COMPARE** (1 cycle)
  - o_ro_en goes to 0.
  - Register o_response = (cnt_a > cnt_b); a tie gives 0.
  - Register o_cnt_a and o_cnt_b.
  - o_err = saturation flag.
  - Go to IDLE.
- **Edge path**, per channel:
  - mux i_ro[sel], then a 2-flop synchronizer, then a registered rising-edge detect.
  - Oscillator frequency is required to be below i_clk/4; faster oscillators alias. Keeping them slower is an integration constraint, not something the block checks.
- **Counters** saturate at 2**CNT_BIT_SIZE-1 and never wrap. Reaching saturation in either channel sets o_err for that measurement.
- **Result hold**: o_response, o_cnt_a, o_cnt_b and o_err hold their value until the next o_done.
- **Reset** (i_rst_n=0 at a clock edge), including mid-measurement: FSM to IDLE, o_ro_en=0, o_busy=0, o_done=0, o_response=0, o_cnt_a=0, o_cnt_b=0, o_err=0, synchronizers and counters cleared.

## Timing
Let T be the cycle where i_start=1 is sampled in IDLE with a legal challenge.

- o_busy=1 and o_ro_en active from T+1 through T+SETTLE_CYCLES+WIN_CYCLES.
- COMPARE occurs at T+SETTLE_CYCLES+WIN_CYCLES+1; o_busy=1 and o_ro_en=0 in that cycle.
- o_done=1 for exactly one cycle at T+SETTLE_CYCLES+WIN_CYCLES+2, with results valid that cycle; o_busy=0.
- The counting window is exactly WIN_CYCLES edge-detector samples.
- i_start while o_busy=1 is ignored; there is no queueing.
- i_start=1 in the same cycle as o_done (FSM is in IDLE) is accepted.
- Illegal challenge sampled at T: o_done=1 and o_err=1 at T+1; o_busy stays 0.
- Changes on i_challenge after T have no effect on the running measurement.

## Structure
- Package puf_ro_ctrl_pkg contains:
  - the state enum (IDLE/SETTLE/MEASURE/COMPARE);
  - default parameter constants;
  - a function that checks challenge legality.
- Sub-module puf_edge_cnt (synchronizer, edge detect, saturating counter with clear/enable), instantiated twice.
- Challenge mux and FSM live in puf_ro_ctrl.

## Test plan
All scenarios use N_RO=16, SETTLE_CYCLES=4, WIN_CYCLES=64, CNT_BIT_SIZE=8.

- **Basic measurement**: i_ro[3] toggles every 2 clocks and i_ro[5] every 4 clocks; start with sel_a=3, sel_b=5.
  - o_ro_en=16'h0028 during T+1..T+68.
  - o_done at T+70 with o_cnt_a=16±1, o_cnt_b=8±1, o_response=1, o_err=0.
- **Swapped selects**: same stimulus as basic, sel_a=5, sel_b=3 → o_response=0.
- **Tie**: both selected oscillators held at 0 → counts 0/0, o_response=0.
- **Illegal challenge**: sel_a=sel_b=7 → o_done and o_err=1 at T+1, o_ro_en stays 0.
- **Saturation**: CNT_BIT_SIZE=4 with i_ro[3] period 4 → o_cnt_a=15, o_err=1.
- **Reset and start rules**:
  - i_rst_n=0 at T+30 → all outputs 0 at T+31, no o_done afterwards.
  - i_start pulsed at T+10 while busy → ignored.
  - i_start in the o_done cycle → new o_busy on the next cycle.
